avmm_rr_arbiter: RTL
====================

Name: avmm_rr_arbiter

Overview:
- Shares one Avalon-MM configuration slave (17-bit address, 32-bit data, byte enables, waitrequest, readdatavalid) between NUM_REQ masters, e.g. the DV sequencer, the calibration FSM and the JTAG bridge.
- Uses round-robin arbitration with at most one outstanding transaction.
- Routes read data back to the issuing master.
- Times out on a missing readdatavalid so the configuration bus cannot hang.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..8).
- AVMM_WIDTH, 32, data width.
- BYTE_WIDTH, 4, byte-enable width (AVMM_WIDTH/8).
- ADDR_WIDTH, 17, address width.
- RD_TIMEOUT, 255, cycles spent in WAIT_RD before a synthetic response; must be ≥1.
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- m_address  in  NUM_REQ*ADDR_WIDTH  per-master address, master i in slice i.
- m_read  in  NUM_REQ  per-master read request.
- m_write  in  NUM_REQ  per-master write request.
- m_writedata  in  NUM_REQ*AVMM_WIDTH  per-master write data.
- m_byteenable  in  NUM_REQ*BYTE_WIDTH  per-master byte enables.
- m_waitrequest  out  NUM_REQ  per-master stall.
- m_readdata  out  AVMM_WIDTH  shared read data bus.
- m_readdatavalid  out  NUM_REQ  per-master read data strobe.
- s_address  out  ADDR_WIDTH  to slave.
- s_read  out  1  to slave.
- s_write  out  1  to slave.
- s_writedata  out  AVMM_WIDTH  to slave.
- s_byteenable  out  BYTE_WIDTH  to slave.
- s_readdata  in  AVMM_WIDTH  from slave.
- s_readdatavalid  in  1  from slave.
- s_waitrequest  in  1  from slave.
- rd_timeout  out  1  sticky flag: a read timed out.
- owner  out  $clog2(NUM_REQ) (min 1)  index of the current or last granted master.

Behaviour:
- Reset (asynchronous, active-high rst):
  - state=IDLE, owner=0, round-robin pointer last=NUM_REQ-1, timeout counter=0, rd_timeout=0.
  - Outputs in reset: m_waitrequest all 1, m_readdatavalid 0, s_read/s_write 0, s_address/s_writedata/s_byteenable 0.
  - Reset mid-transaction abandons the transaction; the slave sees s_read/s_write drop immediately.
- Requests: req[i]=m_read[i]|m_write[i]. If both are set, the write wins and the read is ignored for that transaction.
- IDLE:
  - If any req is set, grant the first requesting index searching last+1, last+2, ... modulo NUM_REQ.
  - Register owner=grant and go to GRANT.
  - s_* outputs are 0 in IDLE.
  - Arbitration costs 1 cycle: a request seen at cycle N drives the slave at cycle N+1.
- GRANT:
  - s_* outputs are driven combinationally from master owner's signals.
  - m_waitrequest[owner]=s_waitrequest; every other bit is 1.
  - Write accepted (s_write & !s_waitrequest): last=owner, go to IDLE.
  - Read accepted: last=owner, clear the counter, go to WAIT_RD.
  - If the owner drops req while s_waitrequest=1: abandon, last unchanged, go to IDLE.
- WAIT_RD:
  - s_read/s_write are 0. All m_waitrequest bits are 1.
  - The counter increments every cycle.
  - s_readdatavalid=1: m_readdatavalid[owner]=1 and m_readdata=s_readdata in the same cycle (combinational), then go to IDLE.
  - counter==RD_TIMEOUT with no valid: m_readdatavalid[owner]=1, m_readdata=TIMEOUT_DATA, set rd_timeout, go to IDLE.
  - If valid and timeout coincide, the real data wins and rd_timeout is not set.
- s_readdatavalid outside WAIT_RD (late response) is dropped: no m_readdatavalid.
- m_readdata equals s_readdata whenever no timeout response is active.
- rd_timeout is cleared only by rst.
- Fairness: a continuously requesting master waits at most NUM_REQ-1 transactions.
- Back-to-back: IDLE is visited between transactions. Minimum is 2 cycles per write with zero-wait slave.

Test Plan:
- Single write: master 0 writes addr 17'h00208, be 4'hF, data 32'h1234_5678; slave waitrequest=0 → s_write high exactly 1 cycle, 1 cycle after request; m_waitrequest[0]=0 that cycle; owner=0.
- Contention: masters 0 and 1 hold writes continuously from reset → grants alternate 0,1,0,1 (first grant 0); each slave write carries the matching master's data.
- Read routing: master 1 reads addr 17'h00010; slave returns 32'hCAFE_0001 three cycles after accept → m_readdatavalid[1] pulses 1 cycle with that data; m_readdatavalid[0] stays 0.
- Timeout: RD_TIMEOUT=4; slave never asserts readdatavalid → m_readdatavalid[owner] with 32'hDEAD_BEEF; rd_timeout=1 and stays 1. A late s_readdatavalid 2 cycles later is ignored.
- Slave stall plus read/write conflict: s_waitrequest held high for 5 cycles on master 0 (m_read=m_write=1) → slave sees a write only; master 1 is not granted until accept.
- Reset mid-WAIT_RD: assert rst → all outputs return to reset values immediately; first grant after release goes to master 0.

Source files
------------

// File: rtl/avmm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM configuration slave among NUM_REQ masters.
// One transaction in flight at a time; reads that never return are answered with TIMEOUT_DATA.
module avmm_rr_arbiter #(
  parameter int unsigned           NUM_REQ      = 2,
  parameter int unsigned           AVMM_WIDTH   = 32,
  parameter int unsigned           BYTE_WIDTH   = 4,
  parameter int unsigned           ADDR_WIDTH   = 17,
  parameter int unsigned           RD_TIMEOUT   = 255,
  parameter logic [AVMM_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]                     m_address,
  input  logic [NUM_REQ-1:0]                                m_read,
  input  logic [NUM_REQ-1:0]                                m_write,
  input  logic [NUM_REQ*AVMM_WIDTH-1:0]                     m_writedata,
  input  logic [NUM_REQ*BYTE_WIDTH-1:0]                     m_byteenable,
  output logic [NUM_REQ-1:0]                                m_waitrequest,
  output logic [AVMM_WIDTH-1:0]                             m_readdata,
  output logic [NUM_REQ-1:0]                                m_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                             s_address,
  output logic                                              s_read,
  output logic                                              s_write,
  output logic [AVMM_WIDTH-1:0]                             s_writedata,
  output logic [BYTE_WIDTH-1:0]                             s_byteenable,
  input  logic [AVMM_WIDTH-1:0]                             s_readdata,
  input  logic                                              s_readdatavalid,
  input  logic                                              s_waitrequest,
  output logic                                              rd_timeout,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]  owner
);

  localparam int unsigned OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W   = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [OWNER_W-1:0]   r_owner;
  logic [OWNER_W-1:0]   w_owner_nxt;
  logic [OWNER_W-1:0]   r_last;
  logic [OWNER_W-1:0]   w_last_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 r_rd_timeout;
  logic                 w_rd_timeout_nxt;

  logic [NUM_REQ-1:0]    w_req;
  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [AVMM_WIDTH-1:0] w_wdata [NUM_REQ];
  logic [BYTE_WIDTH-1:0] w_be [NUM_REQ];
  logic                  w_own_write;
  logic                  w_own_read;
  logic                  w_own_req;
  logic                  w_timeout_hit;
  logic                  w_grant_vld;
  logic [OWNER_W-1:0]    w_grant;

  assign w_req = m_read | m_write;

  // Unpack the per-master buses so the owner can select its slice by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr[gi]  = m_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[gi] = m_writedata[gi*AVMM_WIDTH +: AVMM_WIDTH];
    assign w_be[gi]    = m_byteenable[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // Write has priority over read when a master raises both.
  assign w_own_write   = m_write[r_owner];
  assign w_own_read    = m_read[r_owner] & ~m_write[r_owner];
  assign w_own_req     = w_req[r_owner];
  assign w_timeout_hit = (r_cnt == CNT_W'(RD_TIMEOUT));

  // First requester found searching upward from the master after the last one served.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_grant_vld && w_req[OWNER_W'((32'(r_last) + k) % NUM_REQ)]) begin
        w_grant_vld = 1'b1;
        w_grant     = OWNER_W'((32'(r_last) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last       <= OWNER_W'(NUM_REQ - 1);
      r_cnt        <= '0;
      r_rd_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last       <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rd_timeout <= w_rd_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_nxt       = r_last;
    w_cnt_nxt        = r_cnt;
    w_rd_timeout_nxt = r_rd_timeout;
    m_waitrequest    = '1;
    m_readdatavalid  = '0;
    m_readdata       = s_readdata;
    s_address        = '0;
    s_read           = 1'b0;
    s_write          = 1'b0;
    s_writedata      = '0;
    s_byteenable     = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_owner_nxt = w_grant;
          w_state_nxt = ST_GRANT;
        end
      end

      ST_GRANT: begin
        s_address              = w_addr[r_owner];
        s_writedata            = w_wdata[r_owner];
        s_byteenable           = w_be[r_owner];
        s_write                = w_own_write;
        s_read                 = w_own_read;
        m_waitrequest[r_owner] = s_waitrequest;
        if (w_own_write && !s_waitrequest) begin
          w_last_nxt  = r_owner;
          w_state_nxt = ST_IDLE;
        end else if (w_own_read && !s_waitrequest) begin
          w_last_nxt  = r_owner;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT_RD;
        end else if (!w_own_req) begin
          // Master withdrew before acceptance: drop it without advancing the pointer.
          w_state_nxt = ST_IDLE;
        end
      end

      ST_WAIT_RD: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (s_readdatavalid) begin
          m_readdatavalid[r_owner] = 1'b1;
          w_state_nxt              = ST_IDLE;
        end else if (w_timeout_hit) begin
          m_readdatavalid[r_owner] = 1'b1;
          m_readdata               = TIMEOUT_DATA;
          w_rd_timeout_nxt         = 1'b1;
          w_state_nxt              = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign rd_timeout = r_rd_timeout;
  assign owner      = r_owner;

endmodule
